lapido_ctrl_pipe: RTL and testbench

Pipeline control sequencer for the LAPI DOpaCA LAMBA core. It receives the decoded ID-stage control bundle and delivers that bundle stage by stage to EX, MEM and WB. It detects RAW hazards and stalls for them, and squashes wrong-path instructions on a taken branch or jump. Bubbles are inserted by zeroing write enables and branch/jump bits.

---
 rtl/lapido_ctrl_pipe_if.sv | 54 +++++
 rtl/lapido_ctrl_pipe.sv | 152 +++++++++++++++
 tb/tb_lapido_ctrl_pipe.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lapido_ctrl_pipe_if.sv
// ID-to-sequencer control interface for lapido_ctrl_pipe.
// fwd_a/fwd_b are present only when LAPIDO_CTRL_FWD_EN is defined.
interface lapido_ctrl_pipe_if #(
    parameter int REG_ADDR_W = 5
);
    logic [10:0]           id_ex_ctrl;
    logic [4:0]            id_mem_ctrl;
    logic [2:0]            id_wb_ctrl;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_rs_rd_en;
    logic                  id_rt_rd_en;
    logic                  mem_branch_taken;
    logic [10:0]           ex_ctrl;
    logic [4:0]            mem_ctrl;
    logic [2:0]            wb_ctrl;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] mem_dst;
    logic [REG_ADDR_W-1:0] wb_dst;
    logic                  stall;
    logic                  flush_if_id;
`ifdef LAPIDO_CTRL_FWD_EN
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;

    modport master (
        output id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, id_rs, id_rt, id_rd,
               id_rs_rd_en, id_rt_rd_en, mem_branch_taken,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rs, ex_rt, mem_dst, wb_dst,
               stall, flush_if_id, fwd_a, fwd_b
    );
    modport slave (
        input  id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, id_rs, id_rt, id_rd,
               id_rs_rd_en, id_rt_rd_en, mem_branch_taken,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_rs, ex_rt, mem_dst, wb_dst,
               stall, flush_if_id, fwd_a, fwd_b
    );
`else
    modport master (
        output id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, id_rs, id_rt, id_rd,
               id_rs_rd_en, id_rt_rd_en, mem_branch_taken,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rs, ex_rt, mem_dst, wb_dst,
               stall, flush_if_id
    );
    modport slave (
        input  id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, id_rs, id_rt, id_rd,
               id_rs_rd_en, id_rt_rd_en, mem_branch_taken,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_rs, ex_rt, mem_dst, wb_dst,
               stall, flush_if_id
    );
`endif
endinterface

// File: rtl/lapido_ctrl_pipe.sv
// Pipeline control sequencer: carries ID control bundles through EX/MEM/WB, stalls on RAW
// hazards and squashes wrong-path work. Optional operand forwarding: LAPIDO_CTRL_FWD_EN.
module lapido_ctrl_pipe #(
    parameter int REG_ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    lapido_ctrl_pipe_if.slave bus
);
    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_15 = 2'b10;
    localparam logic [REG_ADDR_W-1:0] REG_LINK = REG_ADDR_W'(15);
`ifdef LAPIDO_CTRL_FWD_EN
    localparam logic [1:0] WB_MEM = 2'b01;
`endif

    typedef struct packed {
        logic [10:0]           ex;
        logic [4:0]            mem;
        logic [2:0]            wb;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dst;
`ifdef LAPIDO_CTRL_FWD_EN
        logic                  rs_en;
        logic                  rt_en;
`endif
    } id_ex_t;

    typedef struct packed {
        logic [4:0]            mem;
        logic [2:0]            wb;
        logic [REG_ADDR_W-1:0] dst;
    } ex_mem_t;

    typedef struct packed {
        logic [2:0]            wb;
        logic [REG_ADDR_W-1:0] dst;
    } mem_wb_t;

    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [REG_ADDR_W-1:0] id_dst;
    logic                  branch_flush;
    logic                  jump_flush;
    logic                  hazard;
    logic                  stall_int;

    function automatic logic src_hit(input logic en, input logic [REG_ADDR_W-1:0] src,
                                     input logic we, input logic [REG_ADDR_W-1:0] dst);
        return en && we && (src == dst);
    endfunction

    // Stage registers; a bubble is the all-zero bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    always_comb begin
        id_dst = bus.id_rt;
        case (bus.id_ex_ctrl[2:1])
            REG_DST_RT: id_dst = bus.id_rt;
            REG_DST_RD: id_dst = bus.id_rd;
            REG_DST_15: id_dst = REG_LINK;
            default:    id_dst = bus.id_rt;
        endcase
    end

    // Next-state: bubbles are injected where a flush or stall squashes the slot.
    always_comb begin
        id_ex_d     = '0;
        id_ex_d.ex  = bus.id_ex_ctrl;
        id_ex_d.mem = bus.id_mem_ctrl;
        id_ex_d.wb  = bus.id_wb_ctrl;
        id_ex_d.rs  = bus.id_rs;
        id_ex_d.rt  = bus.id_rt;
        id_ex_d.dst = id_dst;
`ifdef LAPIDO_CTRL_FWD_EN
        id_ex_d.rs_en = bus.id_rs_rd_en;
        id_ex_d.rt_en = bus.id_rt_rd_en;
`endif
        if (branch_flush || jump_flush || stall_int) begin
            id_ex_d = '0;
        end

        ex_mem_d.mem = id_ex_q.mem;
        ex_mem_d.wb  = id_ex_q.wb;
        ex_mem_d.dst = id_ex_q.dst;
        if (branch_flush) begin
            ex_mem_d = '0;
        end

        mem_wb_d.wb  = ex_mem_q.wb;
        mem_wb_d.dst = ex_mem_q.dst;
    end

    // Outputs: hazard detection, flush priority and (optionally) forwarding selects.
    always_comb begin
        branch_flush = bus.mem_branch_taken && ex_mem_q.mem[0];
        jump_flush   = id_ex_q.ex[0] && !branch_flush;
`ifdef LAPIDO_CTRL_FWD_EN
        hazard = id_ex_q.wb[0] && (id_ex_q.wb[2:1] == WB_MEM) &&
                 (src_hit(bus.id_rs_rd_en, bus.id_rs, 1'b1, id_ex_q.dst) ||
                  src_hit(bus.id_rt_rd_en, bus.id_rt, 1'b1, id_ex_q.dst));
`else
        // WB producers are covered by the write-through register file.
        hazard = src_hit(bus.id_rs_rd_en, bus.id_rs, id_ex_q.wb[0],  id_ex_q.dst)  ||
                 src_hit(bus.id_rt_rd_en, bus.id_rt, id_ex_q.wb[0],  id_ex_q.dst)  ||
                 src_hit(bus.id_rs_rd_en, bus.id_rs, ex_mem_q.wb[0], ex_mem_q.dst) ||
                 src_hit(bus.id_rt_rd_en, bus.id_rt, ex_mem_q.wb[0], ex_mem_q.dst);
`endif
        stall_int = hazard && !branch_flush && !jump_flush;
    end

`ifdef LAPIDO_CTRL_FWD_EN
    always_comb begin
        bus.fwd_a = 2'b00;
        if (src_hit(id_ex_q.rs_en, id_ex_q.rs, ex_mem_q.wb[0], ex_mem_q.dst)) begin
            bus.fwd_a = 2'b01;
        end else if (src_hit(id_ex_q.rs_en, id_ex_q.rs, mem_wb_q.wb[0], mem_wb_q.dst)) begin
            bus.fwd_a = 2'b10;
        end
        bus.fwd_b = 2'b00;
        if (src_hit(id_ex_q.rt_en, id_ex_q.rt, ex_mem_q.wb[0], ex_mem_q.dst)) begin
            bus.fwd_b = 2'b01;
        end else if (src_hit(id_ex_q.rt_en, id_ex_q.rt, mem_wb_q.wb[0], mem_wb_q.dst)) begin
            bus.fwd_b = 2'b10;
        end
    end
`endif

    assign bus.ex_ctrl     = id_ex_q.ex;
    assign bus.mem_ctrl    = ex_mem_q.mem;
    assign bus.wb_ctrl     = mem_wb_q.wb;
    assign bus.ex_rs       = id_ex_q.rs;
    assign bus.ex_rt       = id_ex_q.rt;
    assign bus.mem_dst     = ex_mem_q.dst;
    assign bus.wb_dst      = mem_wb_q.dst;
    assign bus.stall       = stall_int;
    assign bus.flush_if_id = branch_flush || id_ex_q.ex[0];
endmodule

// File: tb/tb_lapido_ctrl_pipe.sv
// Directed, table-driven bench for lapido_ctrl_pipe (expectations adapt to LAPIDO_CTRL_FWD_EN).
module tb_lapido_ctrl_pipe;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lapido_ctrl_pipe_if #(.REG_ADDR_W(AW)) bus ();
    lapido_ctrl_pipe #(.REG_ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] ex;
        logic [4:0]  mem;
        logic [2:0]  wb;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rs_en;
        logic        rt_en;
    } instr_t;

    typedef struct packed {
        logic [10:0] ex;
        logic [4:0]  mem;
        logic [2:0]  wb;
        logic [4:0]  ex_rs;
        logic [4:0]  ex_rt;
        logic [4:0]  mem_dst;
        logic [4:0]  wb_dst;
        logic        stall;
        logic        flush;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;

    typedef struct {
        string  name;
        instr_t id;
        logic   br;
        exp_t   exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic instr_t mk(input logic [10:0] ex, input logic [4:0] mem, input logic [2:0] wb,
                                  input int rs, input int rt, input int rd,
                                  input logic rs_en, input logic rt_en);
        instr_t i;
        i.ex = ex; i.mem = mem; i.wb = wb;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
        i.rs_en = rs_en; i.rt_en = rt_en;
        return i;
    endfunction

    // Encodings: reg_dst RT=00 RD=01 R15=10; wb_res_mux ALU=00 MEM=01 PC=10.
    function automatic instr_t add_i(input int rd, input int rs, input int rt);
        return mk(11'h402, 5'b00000, 3'b001, rs, rt, rd, 1'b1, 1'b1);
    endfunction
    function automatic instr_t sub_i(input int rd, input int rs, input int rt);
        return mk(11'h442, 5'b00000, 3'b001, rs, rt, rd, 1'b1, 1'b1);
    endfunction
    function automatic instr_t load_i(input int rt, input int rs);
        return mk(11'h030, 5'b00000, 3'b011, rs, rt, 0, 1'b1, 1'b0);
    endfunction
    function automatic instr_t beq_i(input int rs, input int rt);
        return mk(11'h440, 5'b00001, 3'b000, rs, rt, 0, 1'b1, 1'b1);
    endfunction
    function automatic instr_t jal_i();
        return mk(11'h005, 5'b00000, 3'b101, 0, 7, 0, 1'b0, 1'b0);
    endfunction
    function automatic instr_t nop_i();
        return mk(11'h000, 5'b00000, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    endfunction

    function automatic exp_t xp(input logic [10:0] ex, input logic [4:0] mem, input logic [2:0] wb,
                                input int ers, input int ert, input int mdst, input int wdst,
                                input logic st, input logic fl, input logic [1:0] fa,
                                input logic [1:0] fb);
        exp_t e;
        e.ex = ex; e.mem = mem; e.wb = wb;
        e.ex_rs = 5'(ers); e.ex_rt = 5'(ert); e.mem_dst = 5'(mdst); e.wb_dst = 5'(wdst);
        e.stall = st; e.flush = fl; e.fa = fa; e.fb = fb;
        return e;
    endfunction

    task automatic add(input string n, input instr_t i, input logic br, input exp_t e);
        vec_t v;
        v.name = n; v.id = i; v.br = br; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input instr_t i, input logic br);
        bus.id_ex_ctrl       = i.ex;
        bus.id_mem_ctrl      = i.mem;
        bus.id_wb_ctrl       = i.wb;
        bus.id_rs            = i.rs;
        bus.id_rt            = i.rt;
        bus.id_rd            = i.rd;
        bus.id_rs_rd_en      = i.rs_en;
        bus.id_rt_rd_en      = i.rt_en;
        bus.mem_branch_taken = br;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_exp(input string tag, input exp_t e);
        chk({tag, ".ex_ctrl"},  16'(bus.ex_ctrl),     16'(e.ex));
        chk({tag, ".mem_ctrl"}, 16'(bus.mem_ctrl),    16'(e.mem));
        chk({tag, ".wb_ctrl"},  16'(bus.wb_ctrl),     16'(e.wb));
        chk({tag, ".ex_rs"},    16'(bus.ex_rs),       16'(e.ex_rs));
        chk({tag, ".ex_rt"},    16'(bus.ex_rt),       16'(e.ex_rt));
        chk({tag, ".mem_dst"},  16'(bus.mem_dst),     16'(e.mem_dst));
        chk({tag, ".wb_dst"},   16'(bus.wb_dst),      16'(e.wb_dst));
        chk({tag, ".stall"},    16'(bus.stall),       16'(e.stall));
        chk({tag, ".flush"},    16'(bus.flush_if_id), 16'(e.flush));
`ifdef LAPIDO_CTRL_FWD_EN
        chk({tag, ".fwd_a"},    16'(bus.fwd_a),       16'(e.fa));
        chk({tag, ".fwd_b"},    16'(bus.fwd_b),       16'(e.fb));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Prefix: RAW between add r2 and a following reader of r2.
`ifdef LAPIDO_CTRL_FWD_EN
        add("f0_add",      add_i(2, 1, 1),  1'b0, xp(11'h000, 5'h00, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        add("f1_sub",      sub_i(6, 2, 4),  1'b0, xp(11'h402, 5'h00, 3'b000, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        add("f2_fwd_exm",  load_i(3, 1),    1'b0, xp(11'h442, 5'h00, 3'b000, 2, 4, 2, 0, 0, 0, 2'b01, 2'b00));
        add("f3_loaduse",  add_i(5, 3, 4),  1'b0, xp(11'h030, 5'h00, 3'b001, 1, 3, 6, 2, 1, 0, 2'b00, 2'b00));
        add("f4_released", add_i(5, 3, 4),  1'b0, xp(11'h000, 5'h00, 3'b001, 0, 0, 3, 6, 0, 0, 2'b00, 2'b00));
        add("f5_fwd_mwb",  nop_i(),         1'b0, xp(11'h402, 5'h00, 3'b011, 3, 4, 0, 3, 0, 0, 2'b10, 2'b00));
        add("f6_drain",    nop_i(),         1'b0, xp(11'h000, 5'h00, 3'b000, 0, 0, 5, 0, 0, 0, 2'b00, 2'b00));
        add("f7_drain",    nop_i(),         1'b0, xp(11'h000, 5'h00, 3'b001, 0, 0, 0, 5, 0, 0, 2'b00, 2'b00));
`else
        add("d0_add",      add_i(2, 1, 1),  1'b0, xp(11'h000, 5'h00, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        add("d1_hzd_ex",   sub_i(6, 2, 4),  1'b0, xp(11'h402, 5'h00, 3'b000, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00));
        add("d2_hzd_mem",  sub_i(6, 2, 4),  1'b0, xp(11'h000, 5'h00, 3'b000, 0, 0, 2, 0, 1, 0, 2'b00, 2'b00));
        add("d3_wb_free",  sub_i(6, 2, 4),  1'b0, xp(11'h000, 5'h00, 3'b001, 0, 0, 0, 2, 0, 0, 2'b00, 2'b00));
        add("d4_sub_ex",   nop_i(),         1'b0, xp(11'h442, 5'h00, 3'b000, 2, 4, 0, 0, 0, 0, 2'b00, 2'b00));
        add("d5_drain",    nop_i(),         1'b0, xp(11'h000, 5'h00, 3'b000, 0, 0, 6, 0, 0, 0, 2'b00, 2'b00));
        add("d6_drain",    nop_i(),         1'b0, xp(11'h000, 5'h00, 3'b001, 0, 0, 0, 6, 0, 0, 2'b00, 2'b00));
`endif
        // Common: jump flush, branch flush over pending load hazard, branch beats jump.
        add("c0_jal",      jal_i(),         1'b0, xp(11'h000, 5'h00, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        add("c1_jflush",   add_i(9, 1, 1),  1'b0, xp(11'h005, 5'h00, 3'b000, 0, 7, 0, 0, 0, 1, 2'b00, 2'b00));
        add("c2_jal_mem",  nop_i(),         1'b0, xp(11'h000, 5'h00, 3'b000, 0, 0, 15, 0, 0, 0, 2'b00, 2'b00));
        add("c3_jal_wb",   beq_i(1, 2),     1'b0, xp(11'h000, 5'h00, 3'b101, 0, 0, 0, 15, 0, 0, 2'b00, 2'b00));
        add("c4_beq_ex",   load_i(3, 1),    1'b0, xp(11'h440, 5'h00, 3'b000, 1, 2, 0, 0, 0, 0, 2'b00, 2'b00));
        add("c5_bflush",   add_i(5, 3, 4),  1'b1, xp(11'h030, 5'h01, 3'b000, 1, 3, 2, 0, 0, 1, 2'b00, 2'b00));
        add("c6_squashed", beq_i(1, 2),     1'b0, xp(11'h000, 5'h00, 3'b000, 0, 0, 0, 2, 0, 0, 2'b00, 2'b00));
        add("c7_beq_ex",   jal_i(),         1'b0, xp(11'h440, 5'h00, 3'b000, 1, 2, 0, 0, 0, 0, 2'b00, 2'b00));
        add("c8_br_and_j", add_i(9, 1, 1),  1'b1, xp(11'h005, 5'h01, 3'b000, 0, 7, 2, 0, 0, 1, 2'b00, 2'b00));
        add("c9_br_unqual", nop_i(),        1'b1, xp(11'h000, 5'h00, 3'b000, 0, 0, 0, 2, 0, 0, 2'b00, 2'b00));

        drive(nop_i(), 1'b0);
        rst = 1'b1;
        #12;
        check_exp("por", xp(11'h000, 5'h00, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        @(negedge clk);
        rst = 1'b0;
        step();

        foreach (vecs[k]) begin
            drive(vecs[k].id, vecs[k].br);
            #2;
            check_exp(vecs[k].name, vecs[k].exp);
            step();
        end

        // Fill every stage, hold a load-use stall, then reset asynchronously mid-cycle.
        drive(add_i(2, 1, 1), 1'b0);
        step();
        drive(add_i(3, 1, 1), 1'b0);
        step();
        drive(load_i(4, 1), 1'b0);
        step();
        drive(sub_i(6, 4, 5), 1'b0);
        #2;
        check_exp("pre_rst", xp(11'h030, 5'h00, 3'b001, 1, 4, 3, 2, 1, 0, 2'b00, 2'b00));
        rst = 1'b1;
        #1;
        check_exp("async_rst", xp(11'h000, 5'h00, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        step();
        check_exp("rst_held", xp(11'h000, 5'h00, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        @(negedge clk);
        rst = 1'b0;
        drive(add_i(2, 1, 1), 1'b0);
        step();
        drive(nop_i(), 1'b0);
        #2;
        check_exp("post_e1", xp(11'h402, 5'h00, 3'b000, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        step();
        check_exp("post_e2", xp(11'h000, 5'h00, 3'b000, 0, 0, 2, 0, 0, 0, 2'b00, 2'b00));
        step();
        check_exp("post_e3", xp(11'h000, 5'h00, 3'b001, 0, 0, 0, 2, 0, 0, 2'b00, 2'b00));
        step();
        check_exp("post_e4", xp(11'h000, 5'h00, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
